interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//   Collects up to NUM_SRC peripheral interrupt lines, latches rising edges as pending,
//   masks them with a software enable register, and presents one prioritised
//   interrupt at a time to the CPU via cpu_interrupt/cpu_interrupt_id. Sits on the IO
//   side of system_bus: its io_* ports attach to the bus io port, and its outputs
//   drive system_bus io_interrupt/io_interrupt_id. No nesting: one interrupt in service.
// PARAMETERS
//   NUM_SRC    8             number of interrupt sources, 1..32; source i has id i
//   BASE_ADDR  32'h0000_1000 byte base address of register window (3 words)
// PORTS
//   clk               in   1   system clock, all state on rising edge
//   rst               in   1   synchronous active-high reset
//   irq_src           in   NUM_SRC  raw peripheral interrupt lines, active-high
//   io_addr           in   32  bus address (byte)
//   io_write_data     in   32  bus write data
//   io_write_en       in   1   bus write strobe, 1-cycle, already gated by device select
//   io_read_data      out  32  bus read data, combinational from io_addr
//   cpu_interrupt     out  1   interrupt request to CPU (registered)
//   cpu_interrupt_id  out  5   id of presented source (registered)
//   irq_ack           in   1   CPU took the trap this cycle (1-cycle pulse)
//   irq_done          in   1   CPU executed mret / handler complete (1-cycle pulse)
// BEHAVIOUR
//   Reset: pending=0, enable=0, irq_prev=0, state=IDLE, cpu_interrupt=0,
//     cpu_interrupt_id=0, active_id=0. Reset mid-operation drops everything, no replay.
//   Edge detect: rise = irq_src & ~irq_prev; irq_prev <= irq_src every cycle.
//     pending[i] <= 1 on rise[i]. Held-high line sets pending once only.
//   Registers (offset from BASE_ADDR, word aligned; bits >= NUM_SRC read 0, ignore writes):
//     0x0 PENDING  R / W1C : write 1 clears bit; rise same cycle as W1C -> set wins.
//     0x4 ENABLE   RW      : mask, 1 = enabled.
//     0x8 ACTIVE   R       : {state==SERVICE, 26'b0, active_id[4:0]}; writes ignored.
//     Any other address: read 0, write ignored.
//   Priority: lowest index among (pending & enable) wins; fixed, no rotation.
//   FSM:
//     IDLE    : if |(pending & enable) -> latch active_id=winner, cpu_interrupt<=1,
//               cpu_interrupt_id<=winner, go PRESENT. Else hold.
//     PRESENT : id held stable, no re-arbitration even if higher priority arrives.
//               irq_ack -> clear pending[active_id] (unless rise on same bit this cycle),
//               cpu_interrupt<=0, go SERVICE.
//               else if pending[active_id]&enable[active_id]==0 (sw cleared/masked)
//               -> cpu_interrupt<=0, go IDLE (withdraw; re-arbitrate next cycle).
//               irq_ack has priority over withdraw in the same cycle.
//     SERVICE : cpu_interrupt=0; new edges still latch to pending. irq_done -> IDLE.
//   irq_ack outside PRESENT and irq_done outside SERVICE are ignored.
//   Latency: irq_src rises in cycle t -> pending set t+1 -> cpu_interrupt high at t+2
//     (if enabled and IDLE). irq_done at t -> IDLE t+1 -> next interrupt visible t+2.
//   cpu_interrupt_id retains last value when cpu_interrupt=0.
//   Enabling a bit whose pending is already 1 triggers presentation (pending is edge-latched).
// TESTING
//   1. ENABLE=0x01, pulse irq_src[0] at t -> cpu_interrupt=1,id=0 at t+2; ack -> PENDING=0, ACTIVE=0x8000_0000; done -> ACTIVE=0.
//   2. ENABLE=0xFF, raise src 5 and 2 same cycle -> id=2 presented; ack, done -> id=5 presented 2 cycles later.
//   3. ENABLE=0x00, pulse src 3 -> no interrupt, PENDING=0x08; write ENABLE=0x08 -> interrupt id=3 within 2 cycles.
//   4. PRESENT id=1, write 0x02 to PENDING (W1C) -> cpu_interrupt drops next cycle, state IDLE, no ack needed.
//   5. SERVICE id=0, pulse src 0 again -> PENDING=0x01, no cpu_interrupt until irq_done, then re-presented id=0.
//   6. PRESENT id=4, assert rst for 1 cycle -> all outputs 0, PENDING=ENABLE=0; stray irq_ack/irq_done ignored.

Source files
------------

// File: rtl/interrupt_controller.sv
// Purpose : latches rising edges of NUM_SRC interrupt lines as pending, masks them with an
//           enable register and presents the lowest-index enabled one to the CPU.
// Latency : irq_src rise at t -> pending at t+1 -> cpu_interrupt at t+2; registers read combinationally.
// Backpressure: one interrupt in service at a time; later edges wait in PENDING until irq_done.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   irq_src             raw peripheral interrupt lines (active-high, edge-latched)
//   io_addr/io_write_*  register window at BASE_ADDR: +0 PENDING (W1C), +4 ENABLE, +8 ACTIVE (RO)
//   io_read_data        combinational read data for io_addr
//   cpu_interrupt(_id)  registered request and id of the presented source
//   irq_ack, irq_done   CPU trap-taken and handler-complete pulses
module interrupt_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        io_addr,
  input  logic [31:0]        io_write_data,
  input  logic               io_write_en,
  output logic [31:0]        io_read_data,
  output logic               cpu_interrupt,
  output logic [4:0]         cpu_interrupt_id,
  input  logic               irq_ack,
  input  logic               irq_done
);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending, enable, irq_prev;
  logic [NUM_SRC-1:0] rise, req, w1c_mask, ack_mask, act_mask;
  logic [4:0]         active_id, active_id_nxt, winner, cpu_interrupt_id_nxt;
  logic               cpu_interrupt_nxt, ack_take;
  logic               sel_pending, sel_enable, sel_active;

  // Write-data bits above NUM_SRC have no backing register.
  logic unused_wdata;
  assign unused_wdata = ^io_write_data;

  assign sel_pending = (io_addr == BASE_ADDR);
  assign sel_enable  = (io_addr == BASE_ADDR + 32'd4);
  assign sel_active  = (io_addr == BASE_ADDR + 32'd8);

  assign rise     = irq_src & ~irq_prev;
  assign req      = pending & enable;
  assign act_mask = ONE << active_id;
  assign w1c_mask = (io_write_en && sel_pending) ? io_write_data[NUM_SRC-1:0] : '0;
  assign ack_mask = ack_take ? act_mask : '0;

  // Register read mux; unimplemented bits and unmapped addresses read as zero.
  always_comb begin
    io_read_data = '0;
    if (sel_pending) begin
      io_read_data[NUM_SRC-1:0] = pending;
    end else if (sel_enable) begin
      io_read_data[NUM_SRC-1:0] = enable;
    end else if (sel_active) begin
      io_read_data = {(state == SERVICE), 26'b0, active_id};
    end
  end

  // Fixed priority: scanning downward leaves the lowest requesting index.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) winner = 5'(i);
    end
  end

  always_comb begin
    state_nxt            = state;
    cpu_interrupt_nxt    = cpu_interrupt;
    cpu_interrupt_id_nxt = cpu_interrupt_id;
    active_id_nxt        = active_id;
    ack_take             = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          active_id_nxt        = winner;
          cpu_interrupt_nxt    = 1'b1;
          cpu_interrupt_id_nxt = winner;
          state_nxt            = PRESENT;
        end
      end
      PRESENT: begin
        // Ack beats withdraw; a higher-priority arrival never displaces the presented id.
        if (irq_ack) begin
          ack_take          = 1'b1;
          cpu_interrupt_nxt = 1'b0;
          state_nxt         = SERVICE;
        end else if (~|(req & act_mask)) begin
          cpu_interrupt_nxt = 1'b0;
          state_nxt         = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pending          <= '0;
      enable           <= '0;
      irq_prev         <= '0;
      active_id        <= '0;
      cpu_interrupt    <= 1'b0;
      cpu_interrupt_id <= '0;
    end else begin
      state            <= state_nxt;
      irq_prev         <= irq_src;
      active_id        <= active_id_nxt;
      cpu_interrupt    <= cpu_interrupt_nxt;
      cpu_interrupt_id <= cpu_interrupt_id_nxt;
      // A rise in the same cycle as a W1C or ack clear keeps the bit set.
      pending          <= (pending & ~w1c_mask & ~ack_mask) | rise;
      if (io_write_en && sel_enable) enable <= io_write_data[NUM_SRC-1:0];
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Purpose : exercises interrupt_controller with directed scenarios and random traffic.
// Latency : outputs compared every cycle, 2 time units after the rising edge.
// Backpressure: none; stimulus is driven on the falling edge.
module tb_interrupt_controller;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int M_IDLE = 0, M_PRESENT = 1, M_SERVICE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_src;
  logic [31:0]   io_addr, io_write_data, io_read_data;
  logic          io_write_en, cpu_interrupt, irq_ack, irq_done;
  logic [4:0]    cpu_interrupt_id;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Behavioural model state
  logic [N-1:0] m_pend, m_en, m_prev;
  int           m_st, m_act, m_id;
  bit           m_irq;

  interrupt_controller #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .io_addr(io_addr), .io_write_data(io_write_data), .io_write_en(io_write_en),
    .io_read_data(io_read_data), .cpu_interrupt(cpu_interrupt),
    .cpu_interrupt_id(cpu_interrupt_id), .irq_ack(irq_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == BASE)        return {24'b0, m_pend};
    if (a == BASE + 4)    return {24'b0, m_en};
    if (a == BASE + 8)    return {(m_st == M_SERVICE), 26'b0, 5'(m_act)};
    return 32'h0;
  endfunction

  // Reference model: updated from the inputs present at each rising edge.
  always @(posedge clk) begin
    logic [N-1:0] rise, np, ne, req;
    int r;
    if (rst) begin
      m_pend = '0; m_en = '0; m_prev = '0;
      m_st = M_IDLE; m_act = 0; m_id = 0; m_irq = 1'b0;
    end else begin
      rise = irq_src & ~m_prev;
      np = m_pend;
      ne = m_en;
      if (io_write_en && io_addr == BASE)     np = np & ~io_write_data[N-1:0];
      if (io_write_en && io_addr == BASE + 4) ne = io_write_data[N-1:0];
      req = m_pend & m_en;
      case (m_st)
        M_IDLE: if (req != 0) begin
          r = int'(req);
          m_act = $clog2(r & -r);   // isolate lowest set bit
          m_id = m_act; m_irq = 1'b1; m_st = M_PRESENT;
        end
        M_PRESENT: if (irq_ack) begin
          np[m_act] = 1'b0; m_irq = 1'b0; m_st = M_SERVICE;
        end else if (!(m_pend[m_act] && m_en[m_act])) begin
          m_irq = 1'b0; m_st = M_IDLE;
        end
        default: if (irq_done) m_st = M_IDLE;
      endcase
      m_pend = np | rise;
      m_en   = ne;
      m_prev = irq_src;
    end
  end

  // Compare process
  always @(posedge clk) begin
    #2;
    if (checking) begin
      chk("cpu_interrupt", {31'b0, cpu_interrupt}, {31'b0, m_irq});
      chk("cpu_interrupt_id", {27'b0, cpu_interrupt_id}, 32'(m_id));
      chk("io_read_data", io_read_data, m_read(io_addr));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr = a; io_write_data = d; io_write_en = 1'b1;
    cyc();
    io_write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    io_addr = a;
    #1;
    chk(name, io_read_data, exp);
  endtask

  task automatic pulse_src(input logic [N-1:0] v);
    irq_src = v; cyc(); irq_src = '0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
  endtask

  task automatic lit_irq(input bit irq, input int id, input string name);
    chk({name, "_irq"}, {31'b0, cpu_interrupt}, {31'b0, irq});
    if (irq) chk({name, "_id"}, {27'b0, cpu_interrupt_id}, 32'(id));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_src = '0; io_addr = BASE; io_write_data = '0;
    io_write_en = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    cyc(2);
    rst = 1'b0;
    checking = 1'b1;
    lit_irq(1'b0, 0, "reset");
    chk("reset_id", {27'b0, cpu_interrupt_id}, 32'h0);
    rd(BASE, 32'h0, "reset_pending");
    rd(BASE + 4, 32'h0, "reset_enable");

    // 1: single source, full ack/done handshake
    wr(BASE + 4, 32'h01);
    pulse_src(8'h01);
    lit_irq(1'b0, 0, "t1_not_yet");
    cyc();
    lit_irq(1'b1, 0, "t1_present");
    pulse_ack();
    rd(BASE, 32'h0, "t1_pending_cleared");
    rd(BASE + 8, 32'h8000_0000, "t1_active_service");
    lit_irq(1'b0, 0, "t1_after_ack");
    pulse_done();
    rd(BASE + 8, 32'h0, "t1_active_idle");

    // 2: simultaneous sources, lowest index first
    wr(BASE + 4, 32'hFF);
    pulse_src(8'h24);
    cyc();
    lit_irq(1'b1, 2, "t2_first");
    pulse_ack();
    pulse_done();
    lit_irq(1'b0, 0, "t2_gap");
    cyc();
    lit_irq(1'b1, 5, "t2_second");
    pulse_ack();
    pulse_done();

    // 3: masked source presented once enabled
    wr(BASE + 4, 32'h00);
    pulse_src(8'h08);
    cyc(2);
    lit_irq(1'b0, 0, "t3_masked");
    rd(BASE, 32'h08, "t3_pending");
    wr(BASE + 4, 32'h08);
    cyc();
    lit_irq(1'b1, 3, "t3_enabled");
    pulse_ack();
    pulse_done();

    // 4: software W1C withdraws a presented interrupt
    wr(BASE + 4, 32'hFF);
    pulse_src(8'h02);
    cyc();
    lit_irq(1'b1, 1, "t4_present");
    wr(BASE, 32'h02);
    cyc();
    lit_irq(1'b0, 0, "t4_withdrawn");
    rd(BASE + 8, 32'h0000_0001, "t4_active_idle");

    // 5: new edge during service waits for irq_done
    pulse_src(8'h01);
    cyc();
    pulse_ack();
    pulse_src(8'h01);
    rd(BASE, 32'h01, "t5_pending_again");
    cyc();
    lit_irq(1'b0, 0, "t5_held_off");
    pulse_done();
    lit_irq(1'b0, 0, "t5_idle");
    cyc();
    lit_irq(1'b1, 0, "t5_represent");
    pulse_ack();
    pulse_done();

    // 6: reset while presenting, then stray handshakes
    pulse_src(8'h10);
    cyc();
    lit_irq(1'b1, 4, "t6_present");
    rst = 1'b1; cyc(); rst = 1'b0;
    lit_irq(1'b0, 0, "t6_reset");
    chk("t6_reset_id", {27'b0, cpu_interrupt_id}, 32'h0);
    rd(BASE, 32'h0, "t6_pending");
    rd(BASE + 4, 32'h0, "t6_enable");
    pulse_ack();
    pulse_done();
    rd(BASE + 8, 32'h0, "t6_stray_ignored");

    // Rise in the same cycle as W1C keeps the bit; upper bits read zero
    io_addr = BASE; io_write_data = 32'h40; io_write_en = 1'b1; irq_src = 8'h40;
    cyc();
    io_write_en = 1'b0; irq_src = '0;
    rd(BASE, 32'h40, "w1c_set_wins");
    wr(BASE, 32'hFF);
    rd(BASE, 32'h0, "w1c_clear");
    wr(BASE + 4, 32'hFFFF_FFFF);
    rd(BASE + 4, 32'h0000_00FF, "enable_width");
    wr(BASE + 8, 32'hFFFF_FFFF);
    rd(BASE + 8, 32'h0, "active_readonly");
    rd(BASE + 12, 32'h0, "unmapped_read");

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(399) == 0);
      irq_src = irq_src ^ N'($urandom & $urandom & $urandom);
      case ($urandom_range(4))
        0: io_addr = BASE;
        1: io_addr = BASE + 4;
        2: io_addr = BASE + 8;
        3: io_addr = BASE + 12;
        default: io_addr = $urandom & 32'h0000_1FFC;
      endcase
      io_write_data = ($urandom_range(1) == 0) ? $urandom : (32'h1 << $urandom_range(N - 1));
      io_write_en = ($urandom_range(7) == 0);
      irq_ack  = (m_st == M_PRESENT) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      irq_done = (m_st == M_SERVICE) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      cyc();
    end
    rst = 1'b0; io_write_en = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
